// File: rtl/aes_dec_pipeline.sv
// AES-128 inverse cipher: sequential key expansion into rk0..rk10, then an
// 11-stage, one-block-per-clock decryption pipeline applying the keys in reverse.
module aes_dec_pipeline #(
    parameter int NR       = 10,
    parameter bit OUT_HOLD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fsm_en,
    input  logic [127:0] KEY,
    input  logic [127:0] IN,
    input  logic         in_valid,
    output logic [127:0] OUT,
    output logic         out_valid,
    output logic         key_ready
);

    if (NR != 10) begin : g_nr_check
        $error("aes_dec_pipeline supports only NR = 10 (AES-128)");
    end

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q;
    logic [3:0]           prev_idx;
    logic [10:0][127:0]   rk_q;
    logic [127:0]         rk_prev, rk_next;
    logic [31:0]          tw, n0, n1, n2, n3;
    logic [10:0][127:0]   st_q, st_d;
    logic [10:0]          vld_q;
    logic                 start, accept;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; byte 0 is the most significant.
    function automatic logic [127:0] inv_round(input logic [127:0] blk, input logic [127:0] key,
                                               input logic last);
        logic [127:0] t, m;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4);
            t[127 - 8 * i -: 8] = inv_sbox(blk[127 - 8 * src -: 8]);
        end
        t = t ^ key;
        m = t;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127 - 32 * c -: 8];
            a1 = t[119 - 32 * c -: 8];
            a2 = t[111 - 32 * c -: 8];
            a3 = t[103 - 32 * c -: 8];
            m[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^
                                   gf_mul(a3, 8'h09);
            m[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^
                                   gf_mul(a3, 8'h0d);
            m[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^
                                   gf_mul(a3, 8'h0b);
            m[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^
                                   gf_mul(a3, 8'h0e);
        end
        return last ? t : m;
    endfunction

    // fsm_en is honoured only outside EXPAND; it restarts expansion and flushes the pipeline.
    assign start     = fsm_en && (state_q != StExpand);
    assign key_ready = (state_q == StReady);
    assign accept    = in_valid && key_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StReady: if (fsm_en) state_d = StExpand;
            StExpand:        if (cnt_q == 4'd10) state_d = StReady;
            default:         state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        rk_prev  = rk_q[prev_idx];
        tw = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]), sbox(rk_prev[7:0]),
              sbox(rk_prev[31:24])} ^ {rcon(cnt_q), 24'h000000};
        n0 = rk_prev[127:96] ^ tw;
        n1 = rk_prev[95:64] ^ n0;
        n2 = rk_prev[63:32] ^ n1;
        n3 = rk_prev[31:0] ^ n2;
        rk_next = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
            rk_q  <= '0;
        end else if (start) begin
            rk_q[0] <= KEY;
            cnt_q   <= 4'd1;
        end else if (state_q == StExpand) begin
            rk_q[cnt_q] <= rk_next;
            cnt_q       <= cnt_q + 4'd1;
        end
    end

    always_comb begin
        st_d[0] = IN ^ rk_q[10];
        for (int s = 1; s <= 10; s++) begin
            st_d[s] = inv_round(st_q[s-1], rk_q[10-s], s == 10);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            vld_q <= '0;
        end else begin
            if (start) vld_q <= '0;
            else       vld_q <= {vld_q[9:0], accept};
            if (accept) st_q[0] <= st_d[0];
            for (int s = 1; s <= 10; s++) begin
                if (vld_q[s-1]) st_q[s] <= st_d[s];
            end
        end
    end

    assign out_valid = vld_q[10];
    assign OUT       = (OUT_HOLD || vld_q[10]) ? st_q[10] : '0;

endmodule
